// File: rtl/multi_channel_adc_avg_if.sv
// Bus between the ADC pins / control side and the multi-channel ADC front end.
interface multi_channel_adc_avg_if #(
  parameter int ADC_WIDTH = 10,
  parameter int CH_NUM    = 2
);
  logic                                 en;
  logic [CH_NUM-1:0][ADC_WIDTH-1:0]     ad_data;
  logic [CH_NUM-1:0]                    ad_clk;
  logic [CH_NUM-1:0]                    ad_oe_n;
  logic [CH_NUM-1:0][ADC_WIDTH-1:0]     data_std;
  logic                                 data_valid;
  logic                                 ovr_clr;
  logic [CH_NUM-1:0]                    ovr_flag;

  modport master (
    output en, ad_data, ovr_clr,
    input  ad_clk, ad_oe_n, data_std, data_valid, ovr_flag
  );

  modport slave (
    input  en, ad_data, ovr_clr,
    output ad_clk, ad_oe_n, data_std, data_valid, ovr_flag
  );
endinterface

// File: rtl/multi_channel_adc_avg.sv
// N-channel offset-binary ADC front end: raw capture, two's-complement conversion,
// block averaging over 2^AVG_LOG2 samples. Optional ADC_OVR_DETECT_EN builds sticky over-range flags.
module multi_channel_adc_avg_lane #(
  parameter int W = 10,
  parameter int L = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         first_i,
  input  logic         last_i,
  input  logic         ovr_clr_i,
  input  logic [W-1:0] code_i,
  output logic [W-1:0] std_o,
  output logic         ovr_o
);
  localparam int AW = W + L;

  logic        [W-1:0]  raw_q;
  logic signed [W-1:0]  std_s;
  logic signed [AW-1:0] std_x, acc_q, acc_base, sum, avg;
  logic        [W-1:0]  data_q;

  // Offset-binary to two's complement is just an MSB flip.
  assign std_s    = {~raw_q[W-1], raw_q[W-2:0]};
  assign std_x    = AW'(std_s);
  assign acc_base = first_i ? '0 : acc_q;
  assign sum      = acc_base + std_x;
  assign avg      = sum >>> L;
  assign std_o    = data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      raw_q  <= '0;
      acc_q  <= '0;
      data_q <= '0;
    end else begin
      raw_q <= code_i;
      if (en_i) begin
        acc_q <= sum;
        if (last_i) data_q <= avg[W-1:0];
      end
    end
  end

`ifdef ADC_OVR_DETECT_EN
  logic ovr_q;
  logic ovr_hit;

  // A fresh hit outranks a clear landing on the same edge.
  assign ovr_hit = (&raw_q) | ~(|raw_q);
  assign ovr_o   = ovr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovr_q <= 1'b0;
    else         ovr_q <= ovr_hit | (ovr_q & ~ovr_clr_i);
  end
`else
  logic unused_clr;
  assign unused_clr = ovr_clr_i;
  assign ovr_o      = 1'b0;
`endif
endmodule

module multi_channel_adc_avg #(
  parameter int ADC_WIDTH = 10,
  parameter int CH_NUM    = 2,
  parameter int AVG_LOG2  = 2
) (
  input  logic                   clk_sample,
  input  logic                   rst_n,
  multi_channel_adc_avg_if.slave bus
);
  localparam int PH_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [PH_W-1:0]                  phase_q, phase_d;
  logic                             first, last;
  logic                             valid_q;
  logic [CH_NUM-1:0][ADC_WIDTH-1:0] code, std;
  logic [CH_NUM-1:0]                ovr;

  assign first = (phase_q == '0);
  assign last  = (AVG_LOG2 == 0) || (phase_q == PH_W'((1 << AVG_LOG2) - 1));

  // Dropping en throws away any partial block and restarts at phase 0.
  always_comb begin
    phase_d = '0;
    if (bus.en && !last) phase_d = phase_q + PH_W'(1);
  end

  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      valid_q <= bus.en & last;
    end
  end

  assign code = bus.ad_data;

  multi_channel_adc_avg_lane #(.W(ADC_WIDTH), .L(AVG_LOG2)) u_lane [CH_NUM-1:0] (
    .clk_i     (clk_sample),
    .rst_ni    (rst_n),
    .en_i      (bus.en),
    .first_i   (first),
    .last_i    (last),
    .ovr_clr_i (bus.ovr_clr),
    .code_i    (code),
    .std_o     (std),
    .ovr_o     (ovr)
  );

  // Converters latch on the falling edge so codes are settled at our rising edge.
  assign bus.ad_clk     = {CH_NUM{~clk_sample}};
  assign bus.ad_oe_n    = '0;
  assign bus.data_std   = std;
  assign bus.data_valid = valid_q;
  assign bus.ovr_flag   = ovr;
endmodule

// File: tb/tb_multi_channel_adc_avg.sv
// Bench for multi_channel_adc_avg: a pass-through (AVG_LOG2=0) and a 4-sample averaging
// instance share stimulus and are checked against a block-sum reference model.
module tb_multi_channel_adc_avg;
  localparam int W  = 10;
  localparam int CH = 2;
`ifdef ADC_OVR_DETECT_EN
  localparam logic OVR_ON = 1'b1;
`else
  localparam logic OVR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_channel_adc_avg_if #(.ADC_WIDTH(W), .CH_NUM(CH)) if0 ();
  multi_channel_adc_avg_if #(.ADC_WIDTH(W), .CH_NUM(CH)) if2 ();

  multi_channel_adc_avg #(.ADC_WIDTH(W), .CH_NUM(CH), .AVG_LOG2(0)) dut0 (
    .clk_sample(clk), .rst_n(rst_n), .bus(if0.slave));
  multi_channel_adc_avg #(.ADC_WIDTH(W), .CH_NUM(CH), .AVG_LOG2(2)) dut2 (
    .clk_sample(clk), .rst_n(rst_n), .bus(if2.slave));

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [CH-1:0][W-1:0] prev, e_s0, e_s2;
  logic                 e_v0, e_v2;
  logic [CH-1:0]        e_o;
  int                   bsum [CH];
  int                   bcnt;

  function automatic int floor_div4(input int s);
    return (s - (((s % 4) + 4) % 4)) / 4;
  endfunction

  task automatic model_reset();
    prev = '0; e_s0 = '0; e_s2 = '0; e_v0 = 1'b0; e_v2 = 1'b0; e_o = '0;
    bsum = '{default: 0}; bcnt = 0;
  endtask

  // One clock: drive both DUTs at negedge, advance the model at posedge, settle.
  task automatic tick(input logic en, input logic [W-1:0] c0, input logic [W-1:0] c1,
                      input logic clr);
    @(negedge clk);
    if0.en = en; if0.ad_data = {c1, c0}; if0.ovr_clr = clr;
    if2.en = en; if2.ad_data = {c1, c0}; if2.ovr_clr = clr;
    @(posedge clk);
    if (en) begin
      for (int c = 0; c < CH; c++) begin
        e_s0[c] = W'(int'(prev[c]) - 512);
        bsum[c] += int'(prev[c]) - 512;
      end
      e_v0 = 1'b1;
      bcnt++;
      if (bcnt == 4) begin
        for (int c = 0; c < CH; c++) e_s2[c] = W'(floor_div4(bsum[c]));
        e_v2 = 1'b1;
        bsum = '{default: 0}; bcnt = 0;
      end else e_v2 = 1'b0;
    end else begin
      e_v0 = 1'b0; e_v2 = 1'b0;
      bsum = '{default: 0}; bcnt = 0;
    end
    for (int c = 0; c < CH; c++) begin
      if (OVR_ON && (prev[c] == '0 || prev[c] == '1)) e_o[c] = 1'b1;
      else if (clr) e_o[c] = 1'b0;
    end
    prev = {c1, c0};
    #1;
  endtask

  task automatic test_reset();
    if0.en = 0; if0.ad_data = '0; if0.ovr_clr = 0;
    if2.en = 0; if2.ad_data = '0; if2.ovr_clr = 0;
    model_reset();
    #3;
    checks++; if (if0.data_valid !== 1'b0 || if0.data_std !== '0) begin
      errors++; $display("FAIL reset dut0 vld=%0b std=%h want 0/0", if0.data_valid, if0.data_std); end
    checks++; if (if2.data_valid !== 1'b0 || if2.data_std !== '0) begin
      errors++; $display("FAIL reset dut2 vld=%0b std=%h want 0/0", if2.data_valid, if2.data_std); end
    checks++; if (if0.ovr_flag !== '0 || if2.ovr_flag !== '0) begin
      errors++; $display("FAIL reset ovr got %b/%b want 00", if0.ovr_flag, if2.ovr_flag); end
    checks++; if (if0.ad_oe_n !== '0 || if0.ad_clk !== {CH{~clk}}) begin
      errors++; $display("FAIL pins oe_n=%b ad_clk=%b clk=%b", if0.ad_oe_n, if0.ad_clk, clk); end
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 10'd512, 10'd0, 1'b0);
      checks++; if (if0.data_valid !== e_v0 || if0.data_std !== e_s0) begin
        errors++; $display("FAIL passthru dut0 vld=%0b/%0b std=%h/%h", if0.data_valid, e_v0, if0.data_std, e_s0); end
      checks++; if (if2.data_valid !== e_v2 || if2.data_std !== e_s2) begin
        errors++; $display("FAIL passthru dut2 vld=%0b/%0b std=%h/%h", if2.data_valid, e_v2, if2.data_std, e_s2); end
      if (i == 1) begin
        checks++; if (if0.data_valid !== 1'b1 || if0.data_std !== {10'h200, 10'h000}) begin
          errors++; $display("FAIL passthru_2edge std=%h want 200000 vld=%0b", if0.data_std, if0.data_valid); end
      end
    end
  endtask

  task automatic run_block(input string nm, input logic [W-1:0] s0, input logic [W-1:0] s1,
                           input logic [W-1:0] s2, input logic [W-1:0] s3,
                           input logic [W-1:0] want);
    logic [W-1:0] seq [5];
    seq[0] = s0; seq[1] = s1; seq[2] = s2; seq[3] = s3; seq[4] = 10'd512;
    for (int i = 0; i < 5; i++) begin
      tick(i != 0, seq[i], 10'd300, 1'b0);
      checks++; if (if2.data_valid !== e_v2 || if2.data_std !== e_s2) begin
        errors++; $display("FAIL %s model vld=%0b/%0b std=%h/%h", nm, if2.data_valid, e_v2, if2.data_std, e_s2); end
      checks++; if (if2.data_valid !== (i == 4)) begin
        errors++; $display("FAIL %s strobe cyc%0d vld=%0b want %0b", nm, i, if2.data_valid, i == 4); end
    end
    checks++; if (if2.data_std[0] !== want) begin
      errors++; $display("FAIL %s value got %h want %h", nm, if2.data_std[0], want); end
  endtask

  task automatic test_en_abort();
    int first_vld = -1;
    for (int i = 0; i < 12; i++) begin
      tick(!(i == 0 || (i >= 3 && i <= 5)), W'($urandom_range(1, 1022)), W'($urandom_range(1, 1022)), 1'b0);
      checks++; if (if2.data_valid !== e_v2 || if2.data_std !== e_s2) begin
        errors++; $display("FAIL en_abort dut2 vld=%0b/%0b std=%h/%h", if2.data_valid, e_v2, if2.data_std, e_s2); end
      checks++; if (if0.data_valid !== e_v0 || if0.data_std !== e_s0) begin
        errors++; $display("FAIL en_abort dut0 vld=%0b/%0b std=%h/%h", if0.data_valid, e_v0, if0.data_std, e_s0); end
      if (if2.data_valid === 1'b1 && first_vld < 0) first_vld = i;
    end
    checks++; if (first_vld != 9) begin
      errors++; $display("FAIL en_abort first_valid cyc=%0d want 9", first_vld); end
  endtask

  task automatic test_ovr();
    logic [W-1:0] c1s [8] = '{10'd500, 10'd500, 10'd1023, 10'd500, 10'd0, 10'd0, 10'd500, 10'd500};
    logic         clrs [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 10'd500, c1s[i], clrs[i]);
      checks++; if (if0.ovr_flag !== e_o || if2.ovr_flag !== e_o) begin
        errors++; $display("FAIL ovr cyc%0d got %b/%b want %b", i, if0.ovr_flag, if2.ovr_flag, e_o); end
      if (i == 4 || i == 5) begin
        checks++; if (if0.ovr_flag !== {OVR_ON, 1'b0}) begin
          errors++; $display("FAIL ovr_sticky cyc%0d got %b want %b", i, if0.ovr_flag, {OVR_ON, 1'b0}); end
      end
    end
    checks++; if (if0.ovr_flag !== 2'b00) begin
      errors++; $display("FAIL ovr_clear got %b want 00", if0.ovr_flag); end
  endtask

  task automatic test_reset_mid();
    int first_vld = -1;
    tick(1'b0, 10'd700, 10'd200, 1'b0);
    tick(1'b1, 10'd700, 10'd200, 1'b0);
    tick(1'b1, 10'd700, 10'd200, 1'b0);
    tick(1'b1, 10'd0,   10'd200, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (if0.data_std !== '0 || if2.data_std !== '0 || if0.data_valid !== 1'b0 || if2.data_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid std=%h/%h vld=%0b/%0b want 0", if0.data_std, if2.data_std, if0.data_valid, if2.data_valid); end
    checks++; if (if0.ovr_flag !== '0 || if2.ovr_flag !== '0) begin
      errors++; $display("FAIL reset_mid ovr=%b/%b want 00", if0.ovr_flag, if2.ovr_flag); end
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(i != 0, W'($urandom_range(1, 1022)), W'($urandom_range(1, 1022)), 1'b1);
      checks++; if (if2.data_valid !== e_v2 || if2.data_std !== e_s2 || if2.ovr_flag !== e_o) begin
        errors++; $display("FAIL reset_mid dut2 vld=%0b/%0b std=%h/%h ovr=%b/%b", if2.data_valid, e_v2, if2.data_std, e_s2, if2.ovr_flag, e_o); end
      if (if2.data_valid === 1'b1 && first_vld < 0) first_vld = i;
    end
    checks++; if (first_vld != 4) begin
      errors++; $display("FAIL reset_mid first_valid cyc=%0d want 4", first_vld); end
  endtask

  task automatic test_back_to_back();
    int n0 = 0, n2 = 0;
    tick(1'b0, 10'd512, 10'd512, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, W'($urandom_range(0, 1023)), W'($urandom_range(0, 1023)), 1'b0);
      n0 += int'(if0.data_valid);
      n2 += int'(if2.data_valid);
      checks++; if (if2.data_valid !== e_v2 || if2.data_std !== e_s2) begin
        errors++; $display("FAIL b2b dut2 vld=%0b/%0b std=%h/%h", if2.data_valid, e_v2, if2.data_std, e_s2); end
    end
    checks++; if (n0 != 16 || n2 != 4) begin
      errors++; $display("FAIL b2b pulses got %0d/%0d want 16/4", n0, n2); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tick(($urandom % 8) != 0, W'($urandom_range(0, 1023)), W'($urandom_range(0, 1023)), ($urandom % 4) == 0);
      checks++; if (if0.data_valid !== e_v0 || if0.data_std !== e_s0) begin
        errors++; $display("FAIL random dut0 cyc%0d vld=%0b/%0b std=%h/%h", i, if0.data_valid, e_v0, if0.data_std, e_s0); end
      checks++; if (if2.data_valid !== e_v2 || if2.data_std !== e_s2) begin
        errors++; $display("FAIL random dut2 cyc%0d vld=%0b/%0b std=%h/%h", i, if2.data_valid, e_v2, if2.data_std, e_s2); end
      checks++; if (if0.ovr_flag !== e_o || if2.ovr_flag !== e_o || if2.ad_clk !== {CH{~clk}}) begin
        errors++; $display("FAIL random ovr cyc%0d got %b/%b want %b ad_clk=%b", i, if0.ovr_flag, if2.ovr_flag, e_o, if2.ad_clk); end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    run_block("pos_avg",   10'd600, 10'd600, 10'd600, 10'd604, 10'd89);
    run_block("neg_floor", 10'd511, 10'd511, 10'd511, 10'd510, 10'h3FE);
    test_en_abort();
    test_ovr();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
